// File: rtl/d_cache_pkg.sv
// Shared definitions for the write-back data cache.
//   state_e   : controller states (IDLE / WB / RF / UNC)
//   SZ_*      : sram-like transfer size encodings
//   byte_mask : byte-lane enables for a (size, addr[1:0]) pair
package d_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RF   = 2'd2,
        UNC  = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: byte_mask = 4'b0001 << addr;
            SZ_HALF: byte_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/d_cache_wb_assoc_if.sv
// sram-like bus: one request channel (req/wr/size/addr/wdata) accepted by addr_ok,
// one response channel (rdata/data_ok).
//   master : issues requests (cache towards memory)
//   slave  : answers requests (cache towards CPU)
interface d_cache_wb_assoc_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
    modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/d_cache_way.sv
// Storage for one cache way: valid, dirty, tag and data words per set.
//   clk, rst         : clock, synchronous active-high reset (clears valid/dirty)
//   i_index, i_word  : shared read/write set index and word select
//   o_valid/o_dirty/o_tag/o_rdata : combinational read of the selected set/word
//   i_wr_en, i_wr_mask, i_wr_data : byte-masked word write
//   i_set_dirty      : mark the set dirty (store hit)
//   i_fill_done      : line refill complete -> valid, new tag, clean
module d_cache_way #(
    parameter int unsigned INDEX_WIDTH = 7,
    parameter int unsigned TAG_WIDTH   = 21,
    parameter int unsigned CNT_WIDTH   = 2,
    parameter int unsigned WORDS       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] i_index,
    input  logic [CNT_WIDTH-1:0]   i_word,
    output logic                   o_valid,
    output logic                   o_dirty,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic [31:0]            o_rdata,
    input  logic                   i_wr_en,
    input  logic [3:0]             i_wr_mask,
    input  logic [31:0]            i_wr_data,
    input  logic                   i_set_dirty,
    input  logic                   i_fill_done,
    input  logic [TAG_WIDTH-1:0]   i_fill_tag
);
    localparam int unsigned SETS = 1 << INDEX_WIDTH;
    localparam int unsigned AW   = $clog2(SETS * WORDS);

    logic [SETS-1:0]      r_valid;
    logic [SETS-1:0]      r_dirty;
    logic [TAG_WIDTH-1:0] r_tag  [SETS];
    logic [31:0]          r_data [SETS*WORDS];
    logic [AW-1:0]        w_addr;

    // Arithmetic form keeps WORDS = 1 (no word bits) legal.
    assign w_addr  = AW'(32'(i_index) * WORDS + 32'(i_word));
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_rdata = r_data[w_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_done) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_set_dirty) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_done) begin
            r_tag[i_index] <= i_fill_tag;
        end
        if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_mask[b]) begin
                    r_data[w_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/d_cache_wb_assoc.sv
// Write-back, write-allocate data cache, 1 or 2 ways, per-set LRU bit.
//   clk, rst   : clock, synchronous active-high reset
//   ades       : address error, request ignored
//   no_dcache  : request bypasses the cache (single uncached transfer)
//   cpu        : sram-like slave port towards the core
//   cache      : sram-like master port towards the AXI bridge
// Misses write back a dirty victim word by word (WB), then refill word by word (RF);
// the held CPU request then hits in IDLE.
module d_cache_wb_assoc
    import d_cache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH  = 7,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned WAYS         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ades,
    input  logic                  no_dcache,
    d_cache_wb_assoc_if.slave     cpu,
    d_cache_wb_assoc_if.master    cache
);
    localparam int unsigned TAG_W = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int unsigned WORDS = 1 << (OFFSET_WIDTH - 2);
    localparam int unsigned CNT_W = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
    localparam int unsigned SETS  = 1 << INDEX_WIDTH;

    state_e                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [TAG_W-1:0]       r_tag;
    logic [INDEX_WIDTH-1:0] r_index;
    logic                   r_way;
    logic                   r_mem_req;
    logic [SETS-1:0]        r_lru;      // way to evict next

    logic [TAG_W-1:0]       w_cpu_tag;
    logic [INDEX_WIDTH-1:0] w_cpu_index;
    logic [CNT_W-1:0]       w_cpu_word;
    logic [INDEX_WIDTH-1:0] w_index;
    logic [CNT_W-1:0]       w_word;
    logic                   w_idle;
    logic [WAYS-1:0]        w_valid;
    logic [WAYS-1:0]        w_dirty;
    logic [TAG_W-1:0]       w_tag   [WAYS];
    logic [31:0]            w_rdata [WAYS];
    logic [WAYS-1:0]        w_hit_vec;
    logic                   w_req_ok;
    logic                   w_hit;
    logic                   w_hit_store;
    logic                   w_hit_way;
    logic                   w_miss;
    logic                   w_unc_start;
    logic                   w_victim;
    logic                   w_victim_dirty;
    logic                   w_rf_dok;
    logic                   w_last;
    logic [TAG_W-1:0]       w_line_tag;
    logic [31:0]            w_way_word;
    logic [3:0]             w_mask;

    assign w_cpu_tag   = cpu.addr[31 -: TAG_W];
    assign w_cpu_index = cpu.addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_cpu_word  = CNT_W'((cpu.addr >> 2) & 32'(WORDS - 1));
    assign w_idle      = (r_state == IDLE);
    // Outside IDLE the arrays are addressed by the captured miss and the word counter.
    assign w_index     = w_idle ? w_cpu_index : r_index;
    assign w_word      = w_idle ? w_cpu_word : r_cnt;
    assign w_mask      = w_idle ? byte_mask(cpu.size, cpu.addr[1:0]) : 4'b1111;

    assign w_req_ok    = cpu.req & ~ades & ~rst;
    assign w_hit       = w_idle & w_req_ok & ~no_dcache & (|w_hit_vec);
    assign w_hit_store = w_hit & cpu.wr;
    assign w_miss      = w_idle & w_req_ok & ~no_dcache & ~(|w_hit_vec);
    assign w_unc_start = w_idle & w_req_ok & no_dcache;
    assign w_rf_dok    = (r_state == RF) & cache.data_ok & ~rst;
    assign w_last      = (r_cnt == CNT_W'(WORDS - 1));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic w_sel;
        assign w_sel        = (r_way == 1'(w));
        assign w_hit_vec[w] = w_valid[w] & (w_tag[w] == w_cpu_tag);

        d_cache_way #(
            .INDEX_WIDTH (INDEX_WIDTH),
            .TAG_WIDTH   (TAG_W),
            .CNT_WIDTH   (CNT_W),
            .WORDS       (WORDS)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .i_index     (w_index),
            .i_word      (w_word),
            .o_valid     (w_valid[w]),
            .o_dirty     (w_dirty[w]),
            .o_tag       (w_tag[w]),
            .o_rdata     (w_rdata[w]),
            .i_wr_en     ((w_hit_store & w_hit_vec[w]) | (w_rf_dok & w_sel)),
            .i_wr_mask   (w_mask),
            .i_wr_data   (w_idle ? cpu.wdata : cache.rdata),
            .i_set_dirty (w_hit_store & w_hit_vec[w]),
            .i_fill_done (w_rf_dok & w_last & w_sel),
            .i_fill_tag  (r_tag)
        );
    end

    always_comb begin
        w_hit_way      = 1'b0;
        w_victim       = 1'b0;
        w_victim_dirty = w_valid[0] & w_dirty[0];
        w_line_tag     = w_tag[0];
        w_way_word     = w_rdata[0];
        if (WAYS == 2) begin
            w_hit_way = w_hit_vec[WAYS-1];
            // First invalid way (way 0 first), otherwise the LRU way.
            if (!w_valid[0])             w_victim = 1'b0;
            else if (!w_valid[WAYS-1])   w_victim = 1'b1;
            else                         w_victim = r_lru[w_cpu_index];
            if (w_victim) w_victim_dirty = w_valid[WAYS-1] & w_dirty[WAYS-1];
            if (r_way)    w_line_tag     = w_tag[WAYS-1];
            if (w_idle ? w_hit_way : r_way) w_way_word = w_rdata[WAYS-1];
        end
        if (r_state != WB) w_line_tag = r_tag;
    end

    assign cpu.addr_ok   = w_hit | ((r_state == UNC) & cache.data_ok & ~rst);
    assign cpu.data_ok   = cpu.addr_ok;
    assign cpu.rdata     = (r_state == UNC) ? cache.rdata : w_way_word;

    assign cache.req     = r_mem_req;
    assign cache.wr      = (r_state == WB) | ((r_state == UNC) & cpu.wr);
    assign cache.size    = (r_state == UNC) ? cpu.size : SZ_WORD;
    assign cache.addr    = (r_state == UNC) ? cpu.addr
                         : {w_line_tag, r_index, OFFSET_WIDTH'({r_cnt, 2'b00})};
    assign cache.wdata   = (r_state == UNC) ? cpu.wdata : w_way_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tag     <= '0;
            r_index   <= '0;
            r_way     <= 1'b0;
            r_mem_req <= 1'b0;
            r_lru     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        if (WAYS == 2) r_lru[w_cpu_index] <= ~w_hit_way;
                    end else if (w_miss) begin
                        r_tag     <= w_cpu_tag;
                        r_index   <= w_cpu_index;
                        r_way     <= w_victim;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b1;
                        r_state   <= w_victim_dirty ? WB : RF;
                    end else if (w_unc_start) begin
                        r_mem_req <= 1'b1;
                        r_state   <= UNC;
                    end
                end
                WB, RF: begin
                    if (r_mem_req && cache.addr_ok) r_mem_req <= 1'b0;
                    // data_ok takes precedence: it may coincide with addr_ok.
                    if (cache.data_ok) begin
                        if (w_last) begin
                            r_cnt     <= '0;
                            r_mem_req <= (r_state == WB);
                            r_state   <= (r_state == WB) ? RF : IDLE;
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                UNC: begin
                    if (r_mem_req && cache.addr_ok) r_mem_req <= 1'b0;
                    if (cache.data_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_wb_assoc.sv
module tb_d_cache_wb_assoc;
    import d_cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ades = 1'b0;
    logic no_dcache = 1'b0;

    always #5 clk = ~clk;

    d_cache_wb_assoc_if cpu_bus ();
    d_cache_wb_assoc_if mem_bus ();

    d_cache_wb_assoc #(
        .INDEX_WIDTH  (7),
        .OFFSET_WIDTH (4),
        .WAYS         (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ades      (ades),
        .no_dcache (no_dcache),
        .cpu       (cpu_bus),
        .cache     (mem_bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    // Backing memory (what the bridge holds) and the architectural view the CPU expects.
    logic [31:0] bmem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0] ^ 16'h0F0F};
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [3:0] tb_mask(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) begin
            case (a)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (sz == 2'd1) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory slave: accepts every request at once, answers one cycle later.
    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;
    txn_t log_q[$];

    logic        s_dok   = 1'b0;
    logic [31:0] s_rdata = '0;
    assign mem_bus.addr_ok = mem_bus.req;
    assign mem_bus.data_ok = s_dok;
    assign mem_bus.rdata   = s_rdata;

    always @(posedge clk) begin
        logic [31:0] wa;
        if (rst) begin
            s_dok <= 1'b0;
        end else begin
            s_dok <= 1'b0;
            if (mem_bus.req) begin
                wa = {mem_bus.addr[31:2], 2'b00};
                log_q.push_back('{mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wdata});
                if (mem_bus.wr)
                    bmem[wa] = merge(bmem_rd(wa), mem_bus.wdata,
                                     tb_mask(mem_bus.size, mem_bus.addr[1:0]));
                else
                    s_rdata <= bmem_rd(wa);
                s_dok <= 1'b1;
            end
        end
    end

    // Scoreboard: pushed at issue, popped on CPU data_ok.
    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && cpu_bus.data_ok) begin
            if (exp_q.size() == 0) begin
                check("spurious_data_ok", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_load) check("load_rdata", cpu_bus.rdata, e.data);
            end
        end
    end

    task automatic cpu_op(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic nc, output int lat);
        logic [31:0] wa;
        exp_t        e;
        wa = {a[31:2], 2'b00};
        if (wr) begin
            ref_mem[wa] = merge(ref_rd(wa), wd, tb_mask(sz, a[1:0]));
            e = '{1'b0, 32'h0};
        end else begin
            e = '{1'b1, ref_rd(wa)};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cpu_bus.req   = 1'b1;
        cpu_bus.wr    = wr;
        cpu_bus.size  = sz;
        cpu_bus.addr  = a;
        cpu_bus.wdata = wd;
        no_dcache     = nc;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_bus.addr_ok) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("addr_ok_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cpu_bus.req = 1'b0;
        no_dcache   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int k;
        int n_aok;
        int n_mreq;

        cpu_bus.req   = 1'b1;
        cpu_bus.wr    = 1'b0;
        cpu_bus.size  = SZ_WORD;
        cpu_bus.addr  = 32'h0000_1004;
        cpu_bus.wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_bus.req), 32'd0);
        check("rst_cpu_ok", 32'(cpu_bus.data_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_bus.req = 1'b0;

        // Cold load: four refill loads, data_ok one cycle after the last refill word
        log_q.delete();
        cpu_op(1'b0, SZ_WORD, 32'h0000_1004, 32'h0, 1'b0, lat);
        check("cold_latency", 32'(lat), 32'd9);
        check("cold_ntxn", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("cold_addr", log_q[i].addr, 32'h1000 + 32'(4 * i));
            check("cold_wr", 32'(log_q[i].wr), 32'd0);
        end

        // Byte store hit, then load of the merged word
        log_q.delete();
        cpu_op(1'b1, SZ_BYTE, 32'h0000_1005, 32'h0000_AB00, 1'b0, lat);
        check("sb_latency", 32'(lat), 32'd0);
        cpu_op(1'b0, SZ_WORD, 32'h0000_1004, 32'h0, 1'b0, lat);
        check("lw_after_sb_latency", 32'(lat), 32'd0);
        check("sb_no_mem", 32'(log_q.size()), 32'd0);

        // Conflict: 0x1000 / 0x1800 / 0x2000 share set 0; evict the clean LRU way
        cpu_op(1'b0, SZ_WORD, 32'h0000_1800, 32'h0, 1'b0, lat);
        cpu_op(1'b0, SZ_WORD, 32'h0000_1000, 32'h0, 1'b0, lat);
        check("touch_1000_hit", 32'(lat), 32'd0);
        log_q.delete();
        cpu_op(1'b0, SZ_WORD, 32'h0000_2008, 32'h0, 1'b0, lat);
        check("conflict_ntxn", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("conflict_addr", log_q[i].addr, 32'h2000 + 32'(4 * i));
            check("conflict_wr", 32'(log_q[i].wr), 32'd0);
        end
        cpu_op(1'b0, SZ_WORD, 32'h0000_100C, 32'h0, 1'b0, lat);
        check("reload_1000_hit", 32'(lat), 32'd0);

        // Dirty eviction of the 0x1000 line
        cpu_op(1'b1, SZ_WORD, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, lat);
        check("sw_hit", 32'(lat), 32'd0);
        log_q.delete();
        cpu_op(1'b0, SZ_WORD, 32'h0000_1800, 32'h0, 1'b0, lat);
        check("fill_1800_ntxn", 32'(log_q.size()), 32'd4);
        cpu_op(1'b0, SZ_WORD, 32'h0000_1804, 32'h0, 1'b0, lat);
        check("touch_1800_hit", 32'(lat), 32'd0);
        log_q.delete();
        cpu_op(1'b0, SZ_WORD, 32'h0000_2000, 32'h0, 1'b0, lat);
        check("evict_ntxn", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            if (i < 4) begin
                check("wb_wr", 32'(log_q[i].wr), 32'd1);
                check("wb_addr", log_q[i].addr, 32'h1000 + 32'(4 * i));
                check("wb_wdata", log_q[i].wdata, ref_rd(32'h1000 + 32'(4 * i)));
                check("wb_size", 32'(log_q[i].sz), 32'(SZ_WORD));
            end else begin
                check("rf_wr", 32'(log_q[i].wr), 32'd0);
                check("rf_addr", log_q[i].addr, 32'h2000 + 32'(4 * (i - 4)));
            end
        end
        // Line comes back from memory with the written-back data
        cpu_op(1'b0, SZ_WORD, 32'h0000_1000, 32'h0, 1'b0, lat);
        check("refetch_latency", 32'(lat), 32'd9);

        // Uncached halfword store and load
        log_q.delete();
        cpu_op(1'b1, SZ_HALF, 32'hBFAF_0002, 32'h1234_0000, 1'b1, lat);
        check("unc_latency", 32'(lat), 32'd2);
        check("unc_ntxn", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) begin
            check("unc_wr", 32'(log_q[0].wr), 32'd1);
            check("unc_size", 32'(log_q[0].sz), 32'd1);
            check("unc_addr", log_q[0].addr, 32'hBFAF_0002);
            check("unc_wdata", log_q[0].wdata, 32'h1234_0000);
        end
        cpu_op(1'b0, SZ_WORD, 32'hBFAF_0000, 32'h0, 1'b1, lat);
        check("unc_load_latency", 32'(lat), 32'd2);
        log_q.delete();
        cpu_op(1'b0, SZ_WORD, 32'h0000_1004, 32'h0, 1'b0, lat);
        check("cached_after_unc_hit", 32'(lat), 32'd0);
        check("cached_after_unc_nomem", 32'(log_q.size()), 32'd0);

        // Address error: request ignored
        @(posedge clk);
        #1;
        ades = 1'b1;
        cpu_bus.req  = 1'b1;
        cpu_bus.wr   = 1'b1;
        cpu_bus.size = SZ_WORD;
        cpu_bus.addr = 32'h0000_1004;
        n_aok = 0;
        n_mreq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_bus.addr_ok) n_aok++;
            if (mem_bus.req) n_mreq++;
        end
        @(posedge clk);
        #1;
        ades = 1'b0;
        cpu_bus.req = 1'b0;
        check("ades_addr_ok", 32'(n_aok), 32'd0);
        check("ades_mem_req", 32'(n_mreq), 32'd0);

        // Reset in the middle of a refill
        @(posedge clk);
        #1;
        cpu_bus.req  = 1'b1;
        cpu_bus.wr   = 1'b0;
        cpu_bus.size = SZ_WORD;
        cpu_bus.addr = 32'h0000_3004;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_bus.data_ok) k++;
            if (k == 2) break;
        end
        check("rf_words_before_rst", 32'(k), 32'd2);
        rst = 1'b1;
        cpu_bus.req = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 32'(mem_bus.req), 32'd0);
        check("midrst_cpu_ok", 32'(cpu_bus.data_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        log_q.delete();
        cpu_op(1'b0, SZ_WORD, 32'h0000_3004, 32'h0, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_ntxn", 32'(log_q.size()), 32'd4);
        log_q.delete();
        cpu_op(1'b0, SZ_WORD, 32'h0000_1804, 32'h0, 1'b0, lat);
        check("post_rst_invalid_miss", 32'(log_q.size()), 32'd4);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/d_cache_wb_assoc.md
Name: d_cache_wb_assoc

Overview:
- Parametrised write-back, write-allocate data cache between the MIPS core's sram-like data port and the AXI bridge's sram-like port.
- Supports 1- or 2-way set associativity with multi-word lines and a per-set LRU bit.
- Dirty-line write-back and line refill run as sequential single-word transactions; no_dcache selects single-word uncached pass-through.

Parameters:
- INDEX_WIDTH, 7, set index bits (sets = 2^INDEX_WIDTH).
- OFFSET_WIDTH, 4, line offset bits (line = 2^OFFSET_WIDTH bytes, WORDS = 2^(OFFSET_WIDTH-2)); legal range 2..6.
- WAYS, 2, associativity; legal values 1 or 2.

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- ades in 1: address error on current request; the request is ignored.
- no_dcache in 1: current request is uncached.
- cpu_data_req in 1: CPU request, held until cpu_data_addr_ok.
- cpu_data_wr in 1: 1 = store.
- cpu_data_size in 2: 0 = byte, 1 = half, 2 = word.
- cpu_data_addr in 32: byte address.
- cpu_data_wdata in 32: store data, byte-lane aligned.
- cpu_data_rdata out 32: load data.
- cpu_data_addr_ok out 1: request accepted.
- cpu_data_data_ok out 1: data returned / write done.
- cache_data_req out 1: memory request.
- cache_data_wr out 1: memory store.
- cache_data_size out 2: memory size.
- cache_data_addr out 32: memory address.
- cache_data_wdata out 32: memory store data.
- cache_data_rdata in 32: memory load data.
- cache_data_addr_ok in 1: memory accepted request.
- cache_data_data_ok in 1: memory data / write done.

Behaviour:
- Address split: tag = [31:INDEX_WIDTH+OFFSET_WIDTH], index, word = [OFFSET_WIDTH-1:2], byte = [1:0].
- Reset: FSM to IDLE; all valid, dirty and LRU bits cleared; word counter = 0; cache_data_req = 0. All cpu_* ok outputs are forced 0 while rst = 1. Reset mid-transaction abandons it; any partial refill is left invalid.
- States:
  - IDLE: service hits.
  - WB: write back victim line.
  - RF: refill line.
  - UNC: uncached access.
- ades = 1 in IDLE: no state change, no ok, no array update.
- IDLE hit (valid & tag match & ~no_dcache):
  - addr_ok and data_ok combinationally in the same cycle as req; rdata = hit way's word.
  - Store merges bytes by size/addr mask and sets dirty.
  - LRU[index] <= the other way (WAYS = 1: no LRU).
  - Arrays update on posedge.
- IDLE miss (cached):
  - Capture tag, index and victim way.
  - Victim = first invalid way (way0 priority), else the LRU way.
  - Victim dirty -> WB, else RF. No cpu ok is asserted during a miss.
- WB: WORDS word stores (size 2) to {victim_tag, index, cnt, 2'b00}, with wdata = victim word cnt.
- RF: WORDS word loads from {saved_tag, index, cnt, 2'b00}. Each data_ok writes word cnt of the victim way.
- Word counter: increments on data_ok and wraps to 0 after the last word.
- After the last WB word: -> RF. After the last RF word: set valid, tag, dirty = 0 -> IDLE. The held request then hits on the next cycle; LRU is updated by that hit.
- Memory handshake: cache_data_req high from the start of each word until addr_ok; then low until data_ok. One transaction outstanding. addr_ok and data_ok in the same cycle counts as both.
- UNC (no_dcache & req & ~ades in IDLE):
  - One transaction with the CPU's size, addr and wdata.
  - cpu_data_addr_ok = cpu_data_data_ok = cache_data_data_ok; rdata = cache_data_rdata; then -> IDLE.
  - Cache arrays untouched. Cached/uncached aliasing is software's responsibility.
- Miss latency (clean, WORDS = 4, memory ok zero-wait): cpu data_ok arrives in the cycle after the last refill data_ok.

Decomposition:
- Package d_cache_pkg holds:
  - state encodings IDLE/WB/RF/UNC;
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - byte-mask function (size, addr[1:0]) -> 4-bit mask.
- Sub-module d_cache_way: one way's storage (valid, dirty, tag, data words) with a combinational read port and a synchronous write port (word select, byte mask, set/clear valid/dirty). It is instantiated WAYS times.

Test Plan:
- Cold load 0x00001004: 4 loads at 0x1000/0x1004/0x1008/0x100C, then cpu data_ok with rdata = memory word at 0x1004. No earlier cpu ok.
- sb 0x000000AB to 0x1005 after fill: addr_ok/data_ok same cycle, no memory request. A following lw 0x1004 returns the old word with byte1 = 0xAB.
- Conflict: fill 0x1000 and 0x1800 (same set), touch 0x1000, load 0x2000: evicts the 0x1800 way (clean, no stores). A reload of 0x1000 hits.
- Dirty eviction: store to 0x1000, fill 0x1800, touch 0x1800, load 0x2000: 4 stores to 0x1000..0x100C carrying line data, then 4 loads 0x2000..0x200C.
- Uncached sh 0x1234 to 0xBFAF0002 with no_dcache: one store, size 1, exact addr. cpu ok on memory data_ok; no array changes. ades = 1 request: no outputs.
- rst asserted after 2 refill words: cache_data_req 0 next cycle, everything invalid. The same load then misses and refills fully.
